trdb_stream_merger: RTL and testbench

TRDB_STREAM_MERGER -- requirements
Module: trdb_stream_merger

---
 rtl/trdb_stream_merger.sv | 221 ++++++++++++++++++++++
 tb/tb_trdb_stream_merger.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_stream_merger.sv
// -----------------------------------------------------------------------------
// trdb_stream_merger
//
// Merges NUM_CH trace packet-word streams (one per traced core) into a single
// registered output stream. Each channel has its own DEPTH-entry FIFO. The
// output register is refilled from the FIFOs in round-robin order. A full
// channel either backpressures its producer or drops words and counts the
// drops, depending on drop_mode_i. A flush request blocks new writes until
// every FIFO and the output register are empty, then pulses flush_done_o.
//
// Ports
//   clk_i         in   clock
//   rst_ni        in   asynchronous active-low reset
//   word_i        in   NUM_CH*XLEN   packet words, channel c at [c*XLEN +: XLEN]
//   word_valid_i  in   NUM_CH        per-channel word valid
//   stall_o       out  NUM_CH        per-channel backpressure
//   drop_mode_i   in   1             1 = drop when full, 0 = stall when full
//   flush_i       in   1             single-cycle drain request
//   flush_done_o  out  1             single-cycle drain-complete pulse
//   word_o        out  XLEN          merged output word (registered)
//   ch_id_o       out  clog2(NUM_CH) source channel of word_o (registered)
//   word_valid_o  out  1             word_o valid (registered)
//   stall_i       in   1             downstream not ready
//   drop_cnt_o    out  NUM_CH*CNT_W  per-channel saturating drop counters
//   drop_clr_i    in   1             clear all drop counters
// -----------------------------------------------------------------------------
module trdb_stream_merger #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH*XLEN-1:0]    word_i,
  input  logic [NUM_CH-1:0]         word_valid_i,
  output logic [NUM_CH-1:0]         stall_o,
  input  logic                      drop_mode_i,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic [XLEN-1:0]           word_o,
  output logic [$clog2(NUM_CH)-1:0] ch_id_o,
  output logic                      word_valid_o,
  input  logic                      stall_i,
  output logic [NUM_CH*CNT_W-1:0]   drop_cnt_o,
  input  logic                      drop_clr_i
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    FL_IDLE,
    FL_DRAIN
  } flush_state_e;

  // FIFO storage and bookkeeping
  logic [XLEN-1:0]   r_mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [LVL_W-1:0]  r_level  [NUM_CH];
  logic [CNT_W-1:0]  r_drop_cnt [NUM_CH];

  // Output register and arbitration pointer
  logic              r_valid;
  logic [XLEN-1:0]   r_word;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_last;

  // Flush control
  flush_state_e      r_fl_state;
  flush_state_e      w_fl_state_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_flush;

  logic [XLEN-1:0]   w_word_in [NUM_CH];
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_drop;
  logic              w_load;
  logic              w_grant_valid;
  logic [CH_W-1:0]   w_grant;
  logic [XLEN-1:0]   w_head;
  logic              w_all_empty;

  assign w_flush     = (r_fl_state == FL_DRAIN);
  assign w_load      = !r_valid || !stall_i;
  assign w_all_empty = (&w_empty) && !r_valid;
  assign w_head      = r_mem[w_grant][r_rd_ptr[w_grant]];

  // Per-channel status. Writes are gated by the registered level only, so a
  // pop in the same cycle never frees a slot for a simultaneous write.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_word_in[c] = word_i[c*XLEN +: XLEN];
      w_full[c]    = (r_level[c] == LVL_W'(DEPTH));
      w_empty[c]   = (r_level[c] == '0);
      w_push[c]    = word_valid_i[c] && !w_full[c] && !w_flush;
      w_drop[c]    = word_valid_i[c] && w_full[c] && drop_mode_i && !w_flush;
      w_pop[c]     = w_load && w_grant_valid && (w_grant == CH_W'(c));
      stall_o[c]   = (w_full[c] && !drop_mode_i) || w_flush;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      drop_cnt_o[c*CNT_W +: CNT_W] = r_drop_cnt[c];
    end
  end

  // Round-robin search: first non-empty FIFO starting after the last grant.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    logic [CH_W-1:0] w_idx;
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_last) + 1 + i) % NUM_CH);
      if (!w_grant_valid && !w_empty[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_idx;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the levels and
  // pointers alone decide which entries hold live data.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= w_word_in[c];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_level[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PTR_W'(1);
        if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + PTR_W'(1);
        r_level[c] <= r_level[c] + LVL_W'(w_push[c]) - LVL_W'(w_pop[c]);
      end
    end
  end

  // Drop counters saturate; a clear coinciding with a drop leaves a count of 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) r_drop_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (drop_clr_i) begin
          r_drop_cnt[c] <= CNT_W'(w_drop[c]);
        end else if (w_drop[c] && (r_drop_cnt[c] != CNT_MAX)) begin
          r_drop_cnt[c] <= r_drop_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  // Output register: refilled whenever it is empty or being consumed, and
  // otherwise held so the word stays stable under downstream stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_ch    <= '0;
      r_last  <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      r_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_word <= w_head;
        r_ch   <= w_grant;
        r_last <= w_grant;
      end
    end
  end

  assign word_o       = r_word;
  assign ch_id_o      = r_ch;
  assign word_valid_o = r_valid;
  assign flush_done_o = r_done;

  // Flush FSM: a request while draining is ignored; completion is seen one
  // edge after everything is empty, so an idle flush completes on the next edge.
  always_comb begin
    w_fl_state_nxt = r_fl_state;
    w_done_nxt     = 1'b0;
    case (r_fl_state)
      FL_IDLE:  if (flush_i) w_fl_state_nxt = FL_DRAIN;
      FL_DRAIN: if (w_all_empty) begin
        w_fl_state_nxt = FL_IDLE;
        w_done_nxt     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fl_state <= FL_IDLE;
      r_done     <= 1'b0;
    end else begin
      r_fl_state <= w_fl_state_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_trdb_stream_merger.sv
// -----------------------------------------------------------------------------
// tb_trdb_stream_merger
//
// Two instances share all inputs: the default-width design and one with 2-bit
// drop counters. A queue-based reference model predicts the merged stream and
// the per-cycle control outputs; a separate monitor pops predicted words on
// each output transfer and compares them.
// -----------------------------------------------------------------------------
module tb_trdb_stream_merger;

  localparam int XLEN      = 32;
  localparam int NUM_CH    = 4;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 16;
  localparam int CNT_W_SAT = 2;
  localparam int CH_W      = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int SAT_MAX   = (1 << CNT_W_SAT) - 1;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [XLEN-1:0] w;
  } out_t;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NUM_CH*XLEN-1:0]      word_i;
  logic [NUM_CH-1:0]           word_valid_i;
  logic                        drop_mode_i;
  logic                        flush_i;
  logic                        stall_i;
  logic                        drop_clr_i;

  logic [NUM_CH-1:0]           stall_o,      sat_stall_o;
  logic                        flush_done_o, sat_flush_done_o;
  logic [XLEN-1:0]             word_o,       sat_word_o;
  logic [CH_W-1:0]             ch_id_o,      sat_ch_id_o;
  logic                        word_valid_o, sat_word_valid_o;
  logic [NUM_CH*CNT_W-1:0]     drop_cnt_o;
  logic [NUM_CH*CNT_W_SAT-1:0] sat_drop_cnt_o;

  always #5 clk = ~clk;

  trdb_stream_merger #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word_i), .word_valid_i(word_valid_i),
    .stall_o(stall_o), .drop_mode_i(drop_mode_i), .flush_i(flush_i),
    .flush_done_o(flush_done_o), .word_o(word_o), .ch_id_o(ch_id_o),
    .word_valid_o(word_valid_o), .stall_i(stall_i), .drop_cnt_o(drop_cnt_o),
    .drop_clr_i(drop_clr_i)
  );

  trdb_stream_merger #(.XLEN(XLEN), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W_SAT)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .word_i(word_i), .word_valid_i(word_valid_i),
    .stall_o(sat_stall_o), .drop_mode_i(drop_mode_i), .flush_i(flush_i),
    .flush_done_o(sat_flush_done_o), .word_o(sat_word_o), .ch_id_o(sat_ch_id_o),
    .word_valid_o(sat_word_valid_o), .stall_i(stall_i), .drop_cnt_o(sat_drop_cnt_o),
    .drop_clr_i(drop_clr_i)
  );

  int errors = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [XLEN-1:0] mq [NUM_CH][$];
  out_t            exp_q[$];
  bit              m_ov;
  int              m_last;
  bit              m_flush;
  bit              m_done;
  int              m_cnt     [NUM_CH];
  int              m_cnt_sat [NUM_CH];

  logic [NUM_CH-1:0] stall_seen = '0;
  logic [CH_W-1:0]   obs_ch[$];
  int                n_xfer = 0;
  int                n_done = 0;

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      mq[k].delete();
      m_cnt[k]     = 0;
      m_cnt_sat[k] = 0;
    end
    exp_q.delete();
    m_ov    = 0;
    m_last  = NUM_CH - 1;
    m_flush = 0;
    m_done  = 0;
  endfunction

  function automatic bit model_idle();
    bit idle;
    idle = !m_ov && (exp_q.size() == 0);
    for (int k = 0; k < NUM_CH; k++) if (mq[k].size() != 0) idle = 0;
    return idle;
  endfunction

  // Per-cycle control outputs vs model, then advance the model over the
  // coming rising edge using the inputs that are stable by now.
  always @(negedge clk) begin
    logic [NUM_CH-1:0]           e_stall;
    logic [NUM_CH*CNT_W-1:0]     e_cnt;
    logic [NUM_CH*CNT_W_SAT-1:0] e_cnt_sat;
    bit                          full [NUM_CH];
    bit                          all_empty;
    bit                          found;
    bit                          dr;
    out_t                        e;

    if (!rst_n) model_reset();

    for (int k = 0; k < NUM_CH; k++) begin
      e_stall[k] = ((mq[k].size() == DEPTH) && !drop_mode_i) || m_flush;
      e_cnt[k*CNT_W +: CNT_W]             = CNT_W'(m_cnt[k]);
      e_cnt_sat[k*CNT_W_SAT +: CNT_W_SAT] = CNT_W_SAT'(m_cnt_sat[k]);
    end
    check("stall_o", 64'(stall_o), 64'(e_stall));
    check("sat_stall_o", 64'(sat_stall_o), 64'(e_stall));
    check("word_valid_o", 64'(word_valid_o), 64'(m_ov));
    check("sat_word_valid_o", 64'(sat_word_valid_o), 64'(m_ov));
    check("flush_done_o", 64'(flush_done_o), 64'(m_done));
    check("sat_flush_done_o", 64'(sat_flush_done_o), 64'(m_done));
    check("drop_cnt_o", 64'(drop_cnt_o), 64'(e_cnt));
    check("sat_drop_cnt_o", 64'(sat_drop_cnt_o), 64'(e_cnt_sat));
    stall_seen = stall_o;

    if (rst_n) begin
      all_empty = !m_ov;
      for (int k = 0; k < NUM_CH; k++) begin
        full[k] = (mq[k].size() == DEPTH);
        if (mq[k].size() != 0) all_empty = 0;
      end
      if (!m_ov || !stall_i) begin
        found = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          int k;
          k = (m_last + 1 + i) % NUM_CH;
          if (!found && mq[k].size() > 0) begin
            found  = 1;
            e.ch   = CH_W'(k);
            e.w    = mq[k].pop_front();
            exp_q.push_back(e);
            m_last = k;
          end
        end
        m_ov = found;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (word_valid_i[k] && !m_flush && !full[k]) mq[k].push_back(word_i[k*XLEN +: XLEN]);
        dr = word_valid_i[k] && full[k] && drop_mode_i && !m_flush;
        if (drop_clr_i) begin
          m_cnt[k]     = dr ? 1 : 0;
          m_cnt_sat[k] = dr ? 1 : 0;
        end else if (dr) begin
          if (m_cnt[k] < CNT_MAX)     m_cnt[k]++;
          if (m_cnt_sat[k] < SAT_MAX) m_cnt_sat[k]++;
        end
      end
      m_done = 0;
      if (m_flush) begin
        if (all_empty) begin
          m_flush = 0;
          m_done  = 1;
        end
      end else if (flush_i) begin
        m_flush = 1;
      end
    end
  end

  // Monitor: each output transfer pops one predicted word.
  always @(negedge clk) begin
    out_t e;
    if (rst_n && word_valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word_valid", 64'(word_valid_o), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("word_o", 64'(word_o), 64'(e.w));
        check("ch_id_o", 64'(ch_id_o), 64'(e.ch));
        check("sat_word_o", 64'(sat_word_o), 64'(e.w));
        check("sat_ch_id_o", 64'(sat_ch_id_o), 64'(e.ch));
        obs_ch.push_back(ch_id_o);
        n_xfer++;
      end
    end
    if (flush_done_o) n_done++;
  end

  // ---------------- stimulus ----------------
  int seq [NUM_CH];

  function automatic logic [XLEN-1:0] mk_word(input int c, input int s);
    return {8'(c + 1), 24'(s)};
  endfunction

  // Advance one clock; a producer moves to its next word once the current
  // one was presented without backpressure at the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int c = 0; c < NUM_CH; c++) begin
      if (word_valid_i[c] && !stall_seen[c]) begin
        seq[c]++;
        word_i[c*XLEN +: XLEN] = mk_word(c, seq[c]);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    word_valid_i = '0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    drop_clr_i   = 1'b0;
    while (n < 100 && !(model_idle() && !word_valid_o)) begin
      tick();
      n++;
    end
    check("drain_bound", 64'(n < 100), 64'(1));
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_o"}, 64'(word_o), 64'(0));
    check({tag, "_ch_id_o"}, 64'(ch_id_o), 64'(0));
    check({tag, "_word_valid_o"}, 64'(word_valid_o), 64'(0));
    check({tag, "_flush_done_o"}, 64'(flush_done_o), 64'(0));
    check({tag, "_stall_o"}, 64'(stall_o), 64'(0));
    check({tag, "_drop_cnt_o"}, 64'(drop_cnt_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0, d0;
    rst_n        = 1'b0;
    word_valid_i = '0;
    stall_i      = 1'b0;
    drop_mode_i  = 1'b0;
    flush_i      = 1'b0;
    drop_clr_i   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      seq[c] = 0;
      word_i[c*XLEN +: XLEN] = mk_word(c, 0);
    end

    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // All channels busy, no downstream stall: strict rotation, one per cycle.
    obs_ch.delete();
    word_valid_i = '1;
    repeat (8) tick();
    n0 = n_xfer;
    repeat (16) tick();
    check("rr_throughput", 64'(n_xfer - n0), 64'(16));
    drain();
    for (int i = 0; i < 16; i++) check("rr_seq", 64'(obs_ch[i]), 64'(i % NUM_CH));

    // Stall mode backpressure on channel 2 with downstream stalled.
    stall_i      = 1'b1;
    s0           = seq[2];
    word_valid_i = 4'b0100;
    repeat (10) tick();
    check("hold_stall2", 64'(stall_o[2]), 64'(1));
    check("hold_accepted", 64'(seq[2] - s0), 64'(5));
    check("hold_nodrop", 64'(drop_cnt_o[2*CNT_W +: CNT_W]), 64'(0));
    drain();

    // Drop mode on channel 1: 10 words -> 5 dropped, then 10 more.
    stall_i      = 1'b1;
    drop_mode_i  = 1'b1;
    word_valid_i = 4'b0010;
    repeat (10) tick();
    word_valid_i = '0;
    check("drop_cnt1", 64'(drop_cnt_o[1*CNT_W +: CNT_W]), 64'(5));
    check("drop_sat1", 64'(sat_drop_cnt_o[1*CNT_W_SAT +: CNT_W_SAT]), 64'(3));
    word_valid_i = 4'b0010;
    repeat (10) tick();
    word_valid_i = '0;
    check("drop_cnt1_more", 64'(drop_cnt_o[1*CNT_W +: CNT_W]), 64'(15));
    check("drop_sat1_more", 64'(sat_drop_cnt_o[1*CNT_W_SAT +: CNT_W_SAT]), 64'(3));

    // Clear coinciding with a drop on channel 0.
    word_valid_i = 4'b0001;
    repeat (4) tick();
    drop_clr_i = 1'b1;
    tick();
    drop_clr_i   = 1'b0;
    word_valid_i = '0;
    check("clr_cnt0", 64'(drop_cnt_o[0 +: CNT_W]), 64'(1));
    check("clr_cnt1", 64'(drop_cnt_o[1*CNT_W +: CNT_W]), 64'(0));
    check("clr_sat0", 64'(sat_drop_cnt_o[0 +: CNT_W_SAT]), 64'(1));
    drop_mode_i = 1'b0;
    drain();

    // Flush with three words buffered.
    stall_i      = 1'b1;
    word_valid_i = 4'b1000;
    repeat (3) tick();
    word_valid_i = '0;
    n0 = n_xfer;
    d0 = n_done;
    flush_i = 1'b1;
    stall_i = 1'b0;
    tick();
    flush_i = 1'b0;
    check("flush_stall_all", 64'(stall_o), 64'(4'b1111));
    repeat (15) tick();
    check("flush_words_out", 64'(n_xfer - n0), 64'(3));
    check("flush_done_once", 64'(n_done - d0), 64'(1));

    // Flush when idle completes on the next cycle.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("idle_flush_pending", 64'(flush_done_o), 64'(0));
    check("idle_flush_stall", 64'(stall_o), 64'(4'b1111));
    tick();
    check("idle_flush_done", 64'(flush_done_o), 64'(1));
    check("idle_flush_released", 64'(stall_o), 64'(0));
    tick();
    check("idle_flush_pulse_end", 64'(flush_done_o), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) drop_mode_i = 1'($urandom_range(0, 1));
      word_valid_i = NUM_CH'($urandom);
      stall_i      = ($urandom_range(0, 3) == 0);
      flush_i      = ($urandom_range(0, 39) == 0);
      drop_clr_i   = ($urandom_range(0, 29) == 0);
      tick();
    end
    drop_mode_i = 1'b0;
    drain();
    repeat (5) tick();

    // Reset mid-operation while a flush is pending.
    stall_i      = 1'b1;
    word_valid_i = '1;
    repeat (4) tick();
    word_valid_i = '0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n   = 1'b1;
    stall_i = 1'b0;
    n0 = n_xfer;
    d0 = n_done;
    repeat (10) tick();
    check("midrst_no_stale", 64'(n_xfer - n0), 64'(0));
    check("midrst_no_done", 64'(n_done - d0), 64'(0));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
